// File: rtl/keypad_cipher_entry_if.sv
// Keypad-to-display bundle for the cipher entry unit: key levels in, display and
// status out. The slave modport is the cipher unit's view.
interface keypad_cipher_entry_if #(
   parameter int DIGITS  = 4,
   parameter int NUM_COM = 8
);
   logic [9:0]          num;
   logic                star;
   logic                sharp;
   logic [6:0]          seg;
   logic [NUM_COM-1:0]  com;
   logic [4*DIGITS-1:0] digits;
   logic [3:0]          key;
   logic [1:0]          state;
   logic                mode;
   logic                result_vld;

   modport master (
      output num, star, sharp,
      input  seg, com, digits, key, state, mode, result_vld
   );

   modport slave (
      input  num, star, sharp,
      output seg, com, digits, key, state, mode, result_vld
   );
endinterface

// File: rtl/keypad_cipher_entry.sv
// Keypad code/key entry with digit-wise mod-10 encrypt/decrypt and a
// multiplexed 7-segment display scan.
module keypad_cipher_entry #(
   parameter int DIGITS   = 4,
   parameter int NUM_COM  = 8,
   parameter int SCAN_DIV = 4
) (
   input logic clk,
   input logic rst,
   keypad_cipher_entry_if.slave bus
);
   localparam int CNT_W  = $clog2(DIGITS + 1);
   localparam int POS_W  = (NUM_COM > 1) ? $clog2(NUM_COM) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]  DIGITS_C = CNT_W'(DIGITS);
   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(NUM_COM - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTER_DATA = 2'd1,
      ENTER_KEY  = 2'd2,
      RESULT     = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic                mode_reg, mode_next;
   logic [4*DIGITS-1:0] digits_reg, digits_next;
   logic [3:0]          key_reg, key_next;
   logic [CNT_W-1:0]    count_reg, count_next;
   logic                key_set_reg, key_set_next;
   logic                result_vld_reg, result_vld_next;
   logic [11:0]         prev_reg;
   logic [SCAN_W-1:0]   scan_cnt_reg;
   logic [POS_W-1:0]    pos_reg;

   logic [11:0]         keys, rise;
   logic                one_press, press_digit, press_star, press_sharp;
   logic [3:0]          digit_val;
   logic [4*DIGITS-1:0] cipher;
   logic [6:0]          seg_val;

   // Key order {sharp, star, num9..num0}; simultaneous new presses cancel each other.
   assign keys        = {bus.sharp, bus.star, bus.num};
   assign rise        = keys & ~prev_reg;
   assign one_press   = (rise != 12'd0) && ((rise & (rise - 12'd1)) == 12'd0);
   assign press_digit = one_press && (rise[9:0] != 10'd0);
   assign press_star  = one_press && rise[10];
   assign press_sharp = one_press && rise[11];

   always_comb begin
      digit_val = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (rise[i]) digit_val = 4'(i);
      end
   end

   // Decrypt adds 10 before subtracting so the 5-bit intermediate never goes negative.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_cipher
         logic [4:0] d5, sum;
         assign d5  = {1'b0, digits_reg[4*gi +: 4]};
         assign sum = mode_reg ? (d5 + 5'd10 - {1'b0, key_reg})
                               : (d5 + {1'b0, key_reg});
         assign cipher[4*gi +: 4] = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      mode_next       = mode_reg;
      digits_next     = digits_reg;
      key_next        = key_reg;
      count_next      = count_reg;
      key_set_next    = key_set_reg;
      result_vld_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (press_star || press_sharp) begin
               state_next   = ENTER_DATA;
               mode_next    = press_sharp;
               digits_next  = '0;
               count_next   = '0;
               key_next     = 4'd0;
               key_set_next = 1'b0;
            end
         end
         ENTER_DATA: begin
            if (press_digit && count_reg < DIGITS_C) begin
               digits_next      = digits_reg << 4;
               digits_next[3:0] = digit_val;
               count_next       = count_reg + 1'b1;
            end else if (press_sharp && count_reg == DIGITS_C) begin
               state_next = ENTER_KEY;
            end else if (press_star) begin
               state_next = IDLE;
            end
         end
         ENTER_KEY: begin
            if (press_digit) begin
               key_next     = digit_val;
               key_set_next = 1'b1;
            end else if (press_sharp && key_set_reg) begin
               state_next      = RESULT;
               digits_next     = cipher;
               result_vld_next = 1'b1;
            end else if (press_star) begin
               state_next = IDLE;
            end
         end
         RESULT: begin
            if (press_star) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Every route back to IDLE wipes the entry registers.
      if (state_next == IDLE && state_reg != IDLE) begin
         mode_next    = 1'b0;
         digits_next  = '0;
         count_next   = '0;
         key_next     = 4'd0;
         key_set_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         mode_reg       <= 1'b0;
         digits_reg     <= '0;
         key_reg        <= 4'd0;
         count_reg      <= '0;
         key_set_reg    <= 1'b0;
         result_vld_reg <= 1'b0;
         prev_reg       <= 12'd0;
         scan_cnt_reg   <= '0;
         pos_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         mode_reg       <= mode_next;
         digits_reg     <= digits_next;
         key_reg        <= key_next;
         count_reg      <= count_next;
         key_set_reg    <= key_set_next;
         result_vld_reg <= result_vld_next;
         prev_reg       <= keys;
         if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            pos_reg      <= (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
         end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
         end
      end
   end

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0: glyph = 7'h3F;
         4'd1: glyph = 7'h06;
         4'd2: glyph = 7'h5B;
         4'd3: glyph = 7'h4F;
         4'd4: glyph = 7'h66;
         4'd5: glyph = 7'h6D;
         4'd6: glyph = 7'h7D;
         4'd7: glyph = 7'h07;
         4'd8: glyph = 7'h7F;
         4'd9: glyph = 7'h6F;
         default: glyph = 7'h00;
      endcase
   endfunction

   always_comb begin
      seg_val = 7'h00;
      for (int i = 0; i < DIGITS; i++) begin
         if (pos_reg == POS_W'(i) &&
             (CNT_W'(i) < count_reg || state_reg == RESULT))
            seg_val = glyph(digits_reg[4*i +: 4]);
      end
      if (pos_reg == POS_LAST && state_reg != IDLE)
         seg_val = mode_reg ? 7'h5E : 7'h79;
   end

   assign bus.seg        = seg_val;
   assign bus.com        = {{(NUM_COM-1){1'b0}}, 1'b1} << pos_reg;
   assign bus.digits     = digits_reg;
   assign bus.key        = key_reg;
   assign bus.state      = state_reg;
   assign bus.mode       = mode_reg;
   assign bus.result_vld = result_vld_reg;
endmodule
